// File: rtl/phemi6_lfsr_pkg.sv
// Shared constants and the advance function for the phemi6 16-bit Fibonacci LFSR.
package phemi6_lfsr_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;
  // Bit mask of s[15], s[13], s[12], s[10]: x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

  localparam int unsigned RUN      = 0;
  localparam int unsigned LOAD_LO  = 1;
  localparam int unsigned LOAD_HI  = 2;
  localparam int unsigned BYTE_SEL = 3;
  localparam int unsigned STEP     = 4;

  // All-zero state would stick forever, so it is kicked to 0x0001.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    if (s == '0) begin
      n = 16'h0001;
    end else begin
      n = {s[LFSR_W-2:0], ^(s & TAP_MASK)};
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr16_core.sv
// LFSR state register: byte loads take priority over advance; everything gated by ena.
module lfsr16_core
  import phemi6_lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_lo,
  input  logic              load_hi,
  input  logic              adv,
  input  logic [7:0]        data,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (ena) begin
      if (load_lo || load_hi) begin
        if (load_lo) state_d[7:0]  = data;
        if (load_hi) state_d[15:8] = data;
      end else if (adv) begin
        state_d = lfsr_next(state_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/phemi6_lfsr.sv
// Tiny Tapeout top for the phemi6 LFSR: step edge detect, output byte mux, uio tie-offs.
// Defining LFSR_SYNC_EN inserts a two-flop synchronizer on ui_in[4:0].
module phemi6_lfsr
  import phemi6_lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [4:0]        ctrl;
  logic              step_q;
  logic              step_edge;
  logic [LFSR_W-1:0] state;
  logic              unused_ui;

`ifdef LFSR_SYNC_EN
  logic [4:0] sync_q1, sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ui_in[4:0];
      sync_q2 <= sync_q1;
    end
  end

  assign ctrl = sync_q2;
`else
  assign ctrl = ui_in[4:0];
`endif

  // Tracks step even while ena=0 so a step held across enable does not fire late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= ctrl[STEP];
    end
  end

  assign step_edge = ctrl[STEP] & ~step_q;

  lfsr16_core #(
    .SEED(SEED)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .load_lo(ctrl[LOAD_LO]),
    .load_hi(ctrl[LOAD_HI]),
    .adv    (ctrl[RUN] | step_edge),
    .data   (uio_in),
    .state  (state)
  );

  assign uo_out    = ctrl[BYTE_SEL] ? state[15:8] : state[7:0];
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign unused_ui = ^ui_in[7:5];

endmodule

// File: tb/tb_phemi6_lfsr.sv
// Directed bench for phemi6_lfsr: stimulus pushes expected bytes, a negedge monitor checks them.
module tb_phemi6_lfsr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  localparam logic [7:0] B_RUN  = 8'h01;
  localparam logic [7:0] B_LO   = 8'h02;
  localparam logic [7:0] B_HI   = 8'h04;
  localparam logic [7:0] B_SEL  = 8'h08;
  localparam logic [7:0] B_STEP = 8'h10;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  phemi6_lfsr dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if (uo_out !== e.exp) begin
        bad++;
        $display("FAIL %s: uo_out got %02h want %02h", e.tag, uo_out, e.exp);
      end
      total++;
      if ({uio_out, uio_oe} !== 16'h0000) begin
        bad++;
        $display("FAIL %s_tie: uio_out/uio_oe got %02h/%02h want 00/00", e.tag, uio_out, uio_oe);
      end
    end
  end

  // Advance n posedges, landing just after the last one.
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expectation; the monitor consumes it on the next falling edge.
  task automatic expect_byte(input string tag, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #17;
    rst_n = 1'b1;

    // Reset state and hold with nothing asserted
    expect_byte("reset_lo", 8'hE1);
    ui_in = B_SEL;
    expect_byte("reset_hi", 8'hAC);
    clocks(10);
    expect_byte("hold_hi", 8'hAC);
    ui_in = 8'h00;
    expect_byte("hold_lo", 8'hE1);

    // Free-running advance: ACE1 -> 59C3 -> B387
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ui_in = B_RUN;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("run1_lo", 8'hC3);
    ui_in = B_RUN;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("run2_lo", 8'h87);
    ui_in = B_SEL;
    expect_byte("run2_hi", 8'hB3);

    // Step held high advances exactly once
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    ui_in = B_STEP;
    clocks(5);
    ui_in = 8'h00;
    expect_byte("step1_lo", 8'hC3);
    ui_in = B_SEL;
    expect_byte("step1_hi", 8'h59);
    ui_in = B_STEP;
    clocks(1);
    ui_in = 8'h00;
    clocks(1);
    expect_byte("step2_lo", 8'h87);

    // Byte loads, and load beats run
    ui_in  = B_LO;
    uio_in = 8'h34;
    clocks(1);
    ui_in  = B_HI;
    uio_in = 8'h12;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("load_lo", 8'h34);
    ui_in = B_SEL;
    expect_byte("load_hi", 8'h12);
    ui_in  = B_LO | B_HI | B_RUN;
    uio_in = 8'h5A;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("load_both_lo", 8'h5A);
    ui_in = B_SEL;
    expect_byte("load_both_hi", 8'h5A);

    // Lock-up guard: 0000 -> 0001 -> 0002
    ui_in  = B_LO | B_HI;
    uio_in = 8'h00;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("zero_lo", 8'h00);
    ui_in = B_STEP;
    clocks(1);
    ui_in = 8'h00;
    clocks(1);
    expect_byte("lockup_lo", 8'h01);
    ui_in = B_STEP;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("lockup2_lo", 8'h02);
    ui_in = B_SEL;
    expect_byte("lockup2_hi", 8'h00);

    // ena=0 ignores run, loads and steps
    ena    = 1'b0;
    ui_in  = B_RUN | B_LO;
    uio_in = 8'hFF;
    clocks(3);
    ui_in = B_STEP;
    clocks(2);
    ui_in = B_HI | B_RUN;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("ena0_lo", 8'h02);
    ui_in = B_SEL;
    expect_byte("ena0_hi", 8'h00);

    // Async reset mid-run, then first edge after release advances
    ena   = 1'b1;
    ui_in = B_RUN;
    clocks(3);
    rst_n = 1'b0;
    expect_byte("async_rst_lo", 8'hE1);
    ui_in = B_RUN | B_SEL;
    expect_byte("async_rst_hi", 8'hAC);
    ui_in = B_RUN;
    rst_n = 1'b1;
    clocks(1);
    ui_in = 8'h00;
    expect_byte("post_rst_lo", 8'hC3);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending got %0d want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
